adder_share_arbiter: RTL and testbench

- Shares one pipelined W-bit adder (a + b, sum plus carry) between NUM_REQ requesters.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- A round-robin arbiter grants one request per cycle.
- Each result is tagged with the requester's index and returned only on that requester's response channel.
- Sits between the per-channel datapath blocks and the single shared arithmetic resource in the top-level design.

---
 rtl/adder_share_arbiter.sv | 118 +++++++++++
 tb/tb_adder_share_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one pipelined W-bit adder between NUM_REQ requesters.
// Results return tagged with the requester index on that requester's response channel.
module adder_share_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]              rsp_valid,
  input  logic [NUM_REQ-1:0]              rsp_ready,
  output logic [DATA_WIDTH-1:0]           rsp_sum,
  output logic                            rsp_carry,
  output logic [$clog2(NUM_REQ)-1:0]      rsp_id,
  output logic                            busy
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam int unsigned LAST = PIPE_STAGES - 1;

  typedef struct packed {
    logic                  valid;
    logic [ID_W-1:0]       id;
    logic                  carry;
    logic [DATA_WIDTH-1:0] sum;
  } stage_t;

  stage_t                pipe_q [PIPE_STAGES];
  stage_t                stage0_d;
  logic [ID_W-1:0]       ptr_q;
  logic [ID_W-1:0]       grant;
  logic                  grant_found;
  logic                  advance;
  logic                  transfer;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;
  logic [DATA_WIDTH:0]   full_sum;
  int unsigned           search_idx;

  // Global stall: everything holds while the head result waits for its owner.
  assign advance  = !pipe_q[LAST].valid || rsp_ready[pipe_q[LAST].id];
  assign transfer = grant_found && advance;

  // Round-robin search from the pointer with modulo wrap (safe for non-power-of-two NUM_REQ).
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    search_idx  = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      search_idx = (32'(ptr_q) + k) % NUM_REQ;
      if (!grant_found && req_valid[ID_W'(search_idx)]) begin
        grant       = ID_W'(search_idx);
        grant_found = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready        = '0;
    req_ready[grant] = transfer;
  end

  // Operand mux and the single shared adder feeding stage 0.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (32'(grant) == i) begin
        op_a = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        op_b = req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    full_sum = {1'b0, op_a} + {1'b0, op_b};
    stage0_d = '0;
    if (transfer) begin
      stage0_d.valid = 1'b1;
      stage0_d.id    = grant;
      stage0_d.carry = full_sum[DATA_WIDTH];
      stage0_d.sum   = full_sum[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
        pipe_q[s] <= '0;
      end
      ptr_q <= '0;
    end else if (advance) begin
      pipe_q[0] <= stage0_d;
      for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
        pipe_q[s] <= pipe_q[s-1];
      end
      if (transfer) begin
        ptr_q <= (32'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
      end
    end
  end

  // Response channel decode from the last stage.
  always_comb begin
    rsp_valid                   = '0;
    rsp_valid[pipe_q[LAST].id]  = pipe_q[LAST].valid;
    busy                        = 1'b0;
    for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
      busy = busy | pipe_q[s].valid;
    end
  end

  assign rsp_sum   = pipe_q[LAST].sum;
  assign rsp_carry = pipe_q[LAST].carry;
  assign rsp_id    = pipe_q[LAST].id;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: queue-based model of in-flight operations checked every cycle,
// plus directed scenarios with literal expectations.
module tb_adder_share_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int P  = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [DW-1:0]   rsp_sum;
  logic            rsp_carry;
  logic [1:0]      rsp_id;
  logic            busy;

  adder_share_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .PIPE_STAGES(P)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .rsp_id(rsp_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
  endtask

  // Model: list of accepted operations, each knowing how many stages deep it is.
  typedef struct {
    int id;
    int sum;
    int carry;
    int depth;
  } op_t;

  op_t m_flight[$];
  int  m_ptr;

  always @(negedge rst_n) begin
    m_flight.delete();
    m_ptr = 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
    end else begin
      bit   out_v;
      bit   adv;
      int   g;
      int   s;
      op_t  e;
      out_v = (m_flight.size() > 0) && (m_flight[0].depth == P - 1);
      chk("model_rsp_valid", 32'(rsp_valid), out_v ? (32'd1 << m_flight[0].id) : 32'd0);
      if (out_v) begin
        chk("model_rsp_sum", 32'(rsp_sum), 32'(m_flight[0].sum));
        chk("model_rsp_carry", 32'(rsp_carry), 32'(m_flight[0].carry));
        chk("model_rsp_id", 32'(rsp_id), 32'(m_flight[0].id));
      end
      chk("model_busy", 32'(busy), 32'(m_flight.size() != 0));
      adv = !out_v || rsp_ready[m_flight[0].id];
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      chk("model_req_ready", 32'(req_ready), (g >= 0 && adv) ? (32'd1 << g) : 32'd0);
      // Apply what the coming rising edge will do.
      if (adv) begin
        if (out_v) void'(m_flight.pop_front());
        foreach (m_flight[i]) m_flight[i].depth++;
        if (g >= 0) begin
          s       = int'(req_a[g*DW +: DW]) + int'(req_b[g*DW +: DW]);
          e.id    = g;
          e.sum   = s % 256;
          e.carry = s / 256;
          e.depth = 0;
          m_flight.push_back(e);
          m_ptr = (g + 1) % N;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  initial begin
    int order [6];
    order = '{0, 1, 2, 3, 0, 1};
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 4'hF;
    tick();
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    chk("rst_rsp_carry", 32'(rsp_carry), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;

    // Requester 2 alone: F0 + 20 -> 10 carry 1, two cycles after acceptance.
    tick();
    set_ops(2, 8'hF0, 8'h20);
    req_valid = 4'b0100;
    #1 chk("lone_req_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    tick();
    #1;
    chk("lone_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("lone_rsp_sum", 32'(rsp_sum), 32'h10);
    chk("lone_rsp_carry", 32'(rsp_carry), 32'd1);
    chk("lone_rsp_id", 32'(rsp_id), 32'd2);

    // Requester 3 alone with FF + 01 -> 00 carry 1; pointer wraps to 0.
    tick();
    set_ops(3, 8'hFF, 8'h01);
    req_valid = 4'b1000;
    #1 chk("wrap_req_ready", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    tick();
    #1;
    chk("ff01_rsp_valid", 32'(rsp_valid), 32'h8);
    chk("ff01_rsp_sum", 32'(rsp_sum), 32'h00);
    chk("ff01_rsp_carry", 32'(rsp_carry), 32'd1);
    tick();

    // All four requesters valid: grants 0,1,2,3,0,1 on consecutive cycles.
    set_ops(0, 8'h00, 8'h00);
    set_ops(1, 8'h12, 8'h34);
    set_ops(2, 8'h80, 8'h80);
    set_ops(3, 8'h7F, 8'h01);
    req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      #1 chk("rr_order", 32'(req_ready), 32'd1 << order[k]);
      if (k == 2) begin
        chk("zero_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("zero_rsp_sum", 32'(rsp_sum), 32'h00);
        chk("zero_rsp_carry", 32'(rsp_carry), 32'd0);
      end
      if (k == 3) chk("rr_rsp_sum1", 32'(rsp_sum), 32'h46);
      tick();
    end
    req_valid = '0;
    repeat (3) tick();

    // Stall: requester 1's result blocked for 5 cycles while requester 0 waits.
    rsp_ready = 4'b1101;
    req_valid = 4'b0010;
    #1 chk("stall_first_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0001;
    tick();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_rsp_valid", 32'(rsp_valid), 32'h2);
      chk("stall_rsp_sum", 32'(rsp_sum), 32'h46);
      chk("stall_rsp_id", 32'(rsp_id), 32'd1);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
      tick();
    end
    rsp_ready = 4'hF;
    #1 chk("release_req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    repeat (3) tick();

    // Pointer at 3 with only 0 and 3 requesting: 3, 0, 3.
    set_ops(2, 8'h01, 8'h02);
    req_valid = 4'b0100;
    #1 chk("ptr3_setup", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b1001;
    #1 chk("ptr3_g0", 32'(req_ready), 32'h8);
    tick();
    #1 chk("ptr3_g1", 32'(req_ready), 32'h1);
    tick();
    #1 chk("ptr3_g2", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    repeat (3) tick();

    // Asynchronous reset with two operations in flight.
    req_valid = 4'b0011;
    tick();
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    req_valid = 4'b0110;
    tick();
    tick();
    rst_n = 1'b1;
    #1 chk("post_reset_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    #1 chk("post_reset_no_stale", 32'(rsp_valid), 32'd0);
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
